alarm_beeper: RTL and testbench

Downstream consumer of the egg-timer alarm. Samples the `alarm` level from the `sec_clk` domain into the system clock domain and drives a piezo buzzer. The buzzer output is a square-wave tone gated by an on/off cadence. Drive stops on user acknowledge, when alarm drops, or after a fixed number of beeps.

---
 rtl/alarm_pkg.sv | 32 +++
 rtl/alarm_sync.sv | 31 +++
 rtl/alarm_beeper.sv | 184 ++++++++++++++++++
 tb/tb_alarm_beeper.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm beeper: state encoding, default
// divider values and small helpers for sizing counters.
package alarm_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BEEP   = 3'd1,
      GAP    = 3'd2,
      DONE   = 3'd3,
      SNOOZE = 3'd4
   } beeper_state_t;

   localparam int unsigned DEF_TONE_DIV     = 25000;
   localparam int unsigned DEF_CADENCE_DIV  = 5000000;
   localparam int unsigned DEF_ON_SLOTS     = 2;
   localparam int unsigned DEF_OFF_SLOTS    = 3;
   localparam int unsigned DEF_MAX_BEEPS    = 30;
   localparam int unsigned DEF_SNOOZE_SLOTS = 50;

   // Counter width for counting 0..n-1; never narrower than one bit.
   function automatic int unsigned widthFor(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned maxOf3(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/alarm_sync.sv
// Brings the sec_clk-domain alarm level into the system clock domain
// through two flops and flags its rising edge.
module alarm_sync (
   input  logic clk,
   input  logic rst,
   input  logic alarm,
   output logic alarm_s,
   output logic alarm_rise
);

   logic alarmMeta;
   logic alarm_s_d;

   // Two-flop synchroniser plus one delay stage for edge detection.
   // The delay stage clears on reset so an alarm that is already high
   // when reset releases still looks like a fresh rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         alarmMeta <= 1'b0;
         alarm_s   <= 1'b0;
         alarm_s_d <= 1'b0;
      end else begin
         alarmMeta <= alarm;
         alarm_s   <= alarmMeta;
         alarm_s_d <= alarm_s;
      end
   end

   assign alarm_rise = alarm_s & ~alarm_s_d;

endmodule

// File: rtl/alarm_beeper.sv
// Piezo driver for the egg-timer alarm. A synchronised alarm rise starts
// a sequence of tone bursts (BEEP) separated by silent gaps (GAP); the
// sequence ends on acknowledge, on alarm drop, or after MAX_BEEPS beeps.
// Optional feature macro: ALARM_BEEPER_SNOOZE_EN turns acknowledge into a
// snooze of SNOOZE_SLOTS cadence slots instead of a hard stop.
module alarm_beeper
   import alarm_pkg::*;
#(
   parameter int unsigned TONE_DIV     = DEF_TONE_DIV,
   parameter int unsigned CADENCE_DIV  = DEF_CADENCE_DIV,
   parameter int unsigned ON_SLOTS     = DEF_ON_SLOTS,
   parameter int unsigned OFF_SLOTS    = DEF_OFF_SLOTS,
   parameter int unsigned MAX_BEEPS    = DEF_MAX_BEEPS,
   parameter int unsigned SNOOZE_SLOTS = DEF_SNOOZE_SLOTS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alarm,
   input  logic       ack,
   output logic       buzzer,
   output logic       beeping,
   output logic [7:0] beep_count
);

   localparam int unsigned TONE_W = widthFor(TONE_DIV);
   localparam int unsigned CAD_W  = widthFor(CADENCE_DIV);
   localparam int unsigned SLOT_W = widthFor(maxOf3(ON_SLOTS, OFF_SLOTS, SNOOZE_SLOTS));

   beeper_state_t     state;
   logic [TONE_W-1:0] toneCnt;
   logic [TONE_W-1:0] toneNext;
   logic [CAD_W-1:0]  cadenceCnt;
   logic [CAD_W-1:0]  cadenceNext;
   logic [SLOT_W-1:0] slotCnt;
   logic [SLOT_W-1:0] slotNext;
   logic [SLOT_W-1:0] slotLast;
   logic              toneWrap;
   logic              cadenceWrap;
   logic              phaseDone;
   logic              moreBeeps;
   logic              alarm_s;
   logic              alarm_rise;

   alarm_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .alarm      (alarm),
      .alarm_s    (alarm_s),
      .alarm_rise (alarm_rise)
   );

   // Next values of the tone and cadence counters, and whether the
   // current timed state has used up its allotted number of slots.
   always_comb begin
      toneWrap    = (toneCnt == TONE_W'(TONE_DIV - 1));
      cadenceWrap = (cadenceCnt == CAD_W'(CADENCE_DIV - 1));
      toneNext    = toneWrap ? '0 : toneCnt + TONE_W'(1);
      cadenceNext = cadenceWrap ? '0 : cadenceCnt + CAD_W'(1);
      slotNext    = cadenceWrap ? slotCnt + SLOT_W'(1) : slotCnt;
      slotLast    = '0;
      case (state)
         BEEP:    slotLast = SLOT_W'(ON_SLOTS - 1);
         GAP:     slotLast = SLOT_W'(OFF_SLOTS - 1);
         SNOOZE:  slotLast = SLOT_W'(SNOOZE_SLOTS - 1);
         default: slotLast = '0;
      endcase
      phaseDone = cadenceWrap && (slotCnt == slotLast);
      moreBeeps = (MAX_BEEPS == 0) || (32'(beep_count) < MAX_BEEPS);
   end

   // Main sequencer. Counters default to zero each cycle so every state
   // entry restarts them; only branches that stay in a timed state advance
   // them. Outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         buzzer     <= 1'b0;
         beeping    <= 1'b0;
         beep_count <= '0;
         toneCnt    <= '0;
         cadenceCnt <= '0;
         slotCnt    <= '0;
      end else begin
         toneCnt    <= '0;
         cadenceCnt <= '0;
         slotCnt    <= '0;
         case (state)
            IDLE: begin
               if (alarm_rise) begin
                  state      <= BEEP;
                  buzzer     <= 1'b1;
                  beeping    <= 1'b1;
                  beep_count <= '0;
               end
            end
            BEEP: begin
               if (!alarm_s) begin
                  state   <= IDLE;
                  buzzer  <= 1'b0;
                  beeping <= 1'b0;
               end else if (ack) begin
`ifdef ALARM_BEEPER_SNOOZE_EN
                  state   <= SNOOZE;
`else
                  state   <= DONE;
`endif
                  buzzer  <= 1'b0;
                  beeping <= 1'b0;
               end else if (phaseDone) begin
                  state  <= GAP;
                  buzzer <= 1'b0;
                  if (beep_count != 8'hFF) begin
                     beep_count <= beep_count + 8'd1;
                  end
               end else begin
                  toneCnt    <= toneNext;
                  cadenceCnt <= cadenceNext;
                  slotCnt    <= slotNext;
                  if (toneWrap) begin
                     buzzer <= ~buzzer;
                  end
               end
            end
            GAP: begin
               if (!alarm_s) begin
                  state   <= IDLE;
                  buzzer  <= 1'b0;
                  beeping <= 1'b0;
               end else if (ack) begin
`ifdef ALARM_BEEPER_SNOOZE_EN
                  state   <= SNOOZE;
`else
                  state   <= DONE;
`endif
                  buzzer  <= 1'b0;
                  beeping <= 1'b0;
               end else if (phaseDone) begin
                  if (moreBeeps) begin
                     state  <= BEEP;
                     buzzer <= 1'b1;
                  end else begin
                     state   <= DONE;
                     buzzer  <= 1'b0;
                     beeping <= 1'b0;
                  end
               end else begin
                  cadenceCnt <= cadenceNext;
                  slotCnt    <= slotNext;
               end
            end
            DONE: begin
               buzzer  <= 1'b0;
               beeping <= 1'b0;
               if (!alarm_s) begin
                  state <= IDLE;
               end
            end
`ifdef ALARM_BEEPER_SNOOZE_EN
            SNOOZE: begin
               if (!alarm_s) begin
                  state <= IDLE;
               end else if (ack) begin
                  state <= DONE;
               end else if (phaseDone) begin
                  state      <= BEEP;
                  buzzer     <= 1'b1;
                  beeping    <= 1'b1;
                  beep_count <= '0;
               end else begin
                  cadenceCnt <= cadenceNext;
                  slotCnt    <= slotNext;
               end
            end
`endif
            default: begin
               state   <= IDLE;
               buzzer  <= 1'b0;
               beeping <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_beeper.sv
// Directed bench for alarm_beeper with small dividers so whole sequences
// fit in a few dozen cycles. Inputs change and outputs are sampled 1 time
// unit after each rising clock edge. The snooze scenario is compiled only
// when ALARM_BEEPER_SNOOZE_EN is defined; otherwise the hard-stop
// acknowledge scenario runs instead.
module tb_alarm_beeper;

   logic       clk;
   logic       rst;
   logic       alarm;
   logic       ack;
   logic       buzzer;
   logic       beeping;
   logic [7:0] beep_count;

   int assertCount;
   int failCount;

   alarm_beeper #(
      .TONE_DIV     (2),
      .CADENCE_DIV  (4),
      .ON_SLOTS     (2),
      .OFF_SLOTS    (1),
      .MAX_BEEPS    (3),
      .SNOOZE_SLOTS (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .alarm      (alarm),
      .ack        (ack),
      .buzzer     (buzzer),
      .beeping    (beeping),
      .beep_count (beep_count)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic rstVal, input logic alarmVal, input logic ackVal);
      rst   = rstVal;
      alarm = alarmVal;
      ack   = ackVal;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic expBuzzer, input logic expBeeping,
                              input logic [7:0] expCount);
      assertCount++;
      assert (buzzer === expBuzzer) else begin
         failCount++;
         $error("[TB] FAIL %s buzzer: got %b, want %b", tag, buzzer, expBuzzer);
      end
      assertCount++;
      assert (beeping === expBeeping) else begin
         failCount++;
         $error("[TB] FAIL %s beeping: got %b, want %b", tag, beeping, expBeeping);
      end
      assertCount++;
      assert (beep_count === expCount) else begin
         failCount++;
         $error("[TB] FAIL %s beep_count: got %0d, want %0d", tag, beep_count, expCount);
      end
   endtask

   // Directed sequence; all expected values are hand-derived from the
   // bench parameters (4-cycle slots, 8-cycle beeps, 4-cycle gaps).
   initial begin
      logic       expBuzz;
      logic [7:0] expCnt;
      int         p;
      assertCount = 0;
      failCount   = 0;

      $display("[TB] reset and idle with alarm low");
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(2);
      checkOutput("reset", 1'b0, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         waitCycles(1);
         checkOutput($sformatf("idle k=%0d", k), 1'b0, 1'b0, 8'd0);
      end

      $display("[TB] alarm held high through a full sequence");
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitCycles(2);
      checkOutput("rise latency", 1'b0, 1'b0, 8'd0);
      waitCycles(1);
      for (int k = 0; k < 36; k++) begin
         p       = k % 12;
         expBuzz = (p < 8) ? ((p % 4) < 2) : 1'b0;
         expCnt  = 8'(k / 12 + ((p >= 8) ? 1 : 0));
         checkOutput($sformatf("seq k=%0d", k), expBuzz, 1'b1, expCnt);
         waitCycles(1);
      end
      checkOutput("done entry", 1'b0, 1'b0, 8'd3);
      for (int k = 0; k < 10; k++) begin
         waitCycles(1);
         checkOutput($sformatf("done hold k=%0d", k), 1'b0, 1'b0, 8'd3);
      end

      $display("[TB] alarm low then high retriggers");
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitCycles(3);
      checkOutput("back to idle", 1'b0, 1'b0, 8'd3);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitCycles(3);
      checkOutput("retrigger", 1'b1, 1'b1, 8'd0);

`ifndef ALARM_BEEPER_SNOOZE_EN
      $display("[TB] acknowledge during beep");
      waitCycles(4);
      checkOutput("pre ack", 1'b1, 1'b1, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitCycles(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("ack done", 1'b0, 1'b0, 8'd0);
      for (int k = 0; k < 10; k++) begin
         waitCycles(1);
         checkOutput($sformatf("ack hold k=%0d", k), 1'b0, 1'b0, 8'd0);
      end
`else
      $display("[TB] acknowledge snoozes during second beep");
      waitCycles(12);
      checkOutput("second beep", 1'b1, 1'b1, 8'd1);
      waitCycles(2);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitCycles(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("snooze k=%0d", k), 1'b0, 1'b0, 8'd1);
         waitCycles(1);
      end
      checkOutput("snooze resume", 1'b1, 1'b1, 8'd0);
      waitCycles(1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitCycles(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("snooze again", 1'b0, 1'b0, 8'd0);
      waitCycles(2);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitCycles(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 12; k++) begin
         checkOutput($sformatf("snooze ack k=%0d", k), 1'b0, 1'b0, 8'd0);
         waitCycles(1);
      end
`endif

      $display("[TB] alarm drop and return to idle");
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitCycles(3);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitCycles(3);
      checkOutput("rearm", 1'b1, 1'b1, 8'd0);

      $display("[TB] alarm drops mid-gap");
      waitCycles(9);
      checkOutput("gap", 1'b0, 1'b1, 8'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitCycles(1);
      checkOutput("drop +1", 1'b0, 1'b1, 8'd1);
      waitCycles(1);
      checkOutput("drop +2", 1'b0, 1'b1, 8'd1);
      waitCycles(1);
      checkOutput("drop idle", 1'b0, 1'b0, 8'd1);

      $display("[TB] reset mid-beep");
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitCycles(3);
      checkOutput("beep again", 1'b1, 1'b1, 8'd0);
      waitCycles(4);
      checkOutput("pre reset", 1'b1, 1'b1, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitCycles(1);
      checkOutput("reset edge", 1'b0, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitCycles(2);
      checkOutput("post reset", 1'b0, 1'b0, 8'd0);
      waitCycles(1);
      checkOutput("high after reset", 1'b1, 1'b1, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
